// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Boot-time loader. Receives a framed program image byte by byte
//             from the UART receiver, assembles little-endian 32-bit words,
//             writes them into program memory while the core is held in
//             reset, verifies an XOR checksum and then hands the memory
//             address port to the fetch stage and releases the core.
//
//             Frame: SYNC_BYTE, LEN_LO, LEN_HI, 4*N data bytes, CSUM.
//
//  Ports    : clk              - clock
//             reset_n          - synchronous active-low reset
//             rx_valid/rx_data - received byte strobe and data
//             rx_error         - UART framing/parity error strobe
//             fetch_address    - fetch-stage byte address (used in RUN)
//             mem_address      - program-memory byte address
//             mem_write_enable - one-cycle program-memory write strobe
//             mem_write_data   - program-memory write word
//             run_flag         - core may run
//             cpu_reset_n      - active-low core/pipeline reset
//             load_error       - last frame rejected
//             busy             - frame in progress (LEN, DATA, CSUM)
//             words_loaded     - words written in current/last frame
//
//  Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int         MEM_WORDS      = 1024,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_error,
    input  logic [31:0] fetch_address,
    output logic [31:0] mem_address,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    output logic        run_flag,
    output logic        cpu_reset_n,
    output logic        load_error,
    output logic        busy,
    output logic [15:0] words_loaded
);

    // Idle counter only needs to hold TIMEOUT_CYCLES-1; the cycle that
    // would take it to TIMEOUT_CYCLES is the one that aborts.
    localparam int              c_TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     c_MAX_LEN = 17'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t            r_state_q,  w_state_d;
    logic [15:0]       r_len_q,    w_len_d;
    logic [7:0]        r_len_lo_q, w_len_lo_d;
    logic [1:0]        r_idx_q,    w_idx_d;
    logic [23:0]       r_word_q,   w_word_d;
    logic [7:0]        r_xor_q,    w_xor_d;
    logic [15:0]       r_words_q,  w_words_d;
    logic [31:0]       r_addr_q,   w_addr_d;
    logic              r_we_q,     w_we_d;
    logic [31:0]       r_wdata_q,  w_wdata_d;
    logic              r_run_q,    w_run_d;
    logic              r_busy_q,   w_busy_d;
    logic              r_err_q,    w_err_d;
    logic [c_TO_W-1:0] r_idle_q,   w_idle_d;

    logic        w_accept;
    logic        w_in_frame;
    logic        w_timeout;
    logic [15:0] w_len_full;
    logic        w_len_bad;
    logic [15:0] w_words_inc;

    // A byte that arrives together with an error strobe is discarded.
    assign w_accept    = rx_valid && !rx_error;
    assign w_in_frame  = (r_state_q == S_LEN) || (r_state_q == S_DATA) || (r_state_q == S_CSUM);
    assign w_timeout   = w_in_frame && !rx_valid && (r_idle_q == c_TO_LAST);
    assign w_len_full  = {rx_data, r_len_lo_q};
    assign w_len_bad   = (w_len_full == 16'd0) || ({1'b0, w_len_full} > c_MAX_LEN);
    assign w_words_inc = r_words_q + 16'd1;

    always_comb begin
        w_state_d  = r_state_q;
        w_len_d    = r_len_q;
        w_len_lo_d = r_len_lo_q;
        w_idx_d    = r_idx_q;
        w_word_d   = r_word_q;
        w_xor_d    = r_xor_q;
        w_words_d  = r_words_q;
        w_addr_d   = r_addr_q;
        w_we_d     = 1'b0;
        w_wdata_d  = r_wdata_q;
        w_idle_d   = '0;

        if (w_in_frame && !rx_valid) begin
            w_idle_d = r_idle_q + 1'b1;
        end

        case (r_state_q)
            S_IDLE, S_ERROR: begin
                if (w_accept && (rx_data == SYNC_BYTE)) begin
                    w_state_d = S_LEN;
                    w_words_d = 16'd0;
                    w_xor_d   = 8'd0;
                    w_idx_d   = 2'd0;
                end
            end

            S_LEN: begin
                if (w_accept) begin
                    if (r_idx_q == 2'd0) begin
                        w_len_lo_d = rx_data;
                        w_idx_d    = 2'd1;
                    end else begin
                        w_len_d   = w_len_full;
                        w_idx_d   = 2'd0;
                        w_state_d = w_len_bad ? S_ERROR : S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (w_accept) begin
                    w_xor_d = r_xor_q ^ rx_data;
                    w_idx_d = r_idx_q + 2'd1;
                    case (r_idx_q)
                        2'd0:    w_word_d[7:0]   = rx_data;
                        2'd1:    w_word_d[15:8]  = rx_data;
                        2'd2:    w_word_d[23:16] = rx_data;
                        default: begin
                            w_we_d    = 1'b1;
                            w_addr_d  = {14'd0, r_words_q, 2'b00};
                            w_wdata_d = {rx_data, r_word_q};
                            w_words_d = w_words_inc;
                            if (w_words_inc == r_len_q) begin
                                w_state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end

            S_CSUM: begin
                if (w_accept) begin
                    w_state_d = (rx_data == r_xor_q) ? S_RUN : S_ERROR;
                end
            end

            S_RUN: begin
                // Terminal until reset; all receiver traffic is ignored.
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Aborts override whatever the byte handling decided.
        if (w_in_frame && (rx_error || w_timeout)) begin
            w_state_d = S_ERROR;
        end

        w_run_d  = (w_state_d == S_RUN);
        w_err_d  = (w_state_d == S_ERROR);
        w_busy_d = (w_state_d == S_LEN) || (w_state_d == S_DATA) || (w_state_d == S_CSUM);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state_q  <= S_IDLE;
            r_len_q    <= '0;
            r_len_lo_q <= '0;
            r_idx_q    <= '0;
            r_word_q   <= '0;
            r_xor_q    <= '0;
            r_words_q  <= '0;
            r_addr_q   <= '0;
            r_we_q     <= 1'b0;
            r_wdata_q  <= '0;
            r_run_q    <= 1'b0;
            r_busy_q   <= 1'b0;
            r_err_q    <= 1'b0;
            r_idle_q   <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_len_q    <= w_len_d;
            r_len_lo_q <= w_len_lo_d;
            r_idx_q    <= w_idx_d;
            r_word_q   <= w_word_d;
            r_xor_q    <= w_xor_d;
            r_words_q  <= w_words_d;
            r_addr_q   <= w_addr_d;
            r_we_q     <= w_we_d;
            r_wdata_q  <= w_wdata_d;
            r_run_q    <= w_run_d;
            r_busy_q   <= w_busy_d;
            r_err_q    <= w_err_d;
            r_idle_q   <= w_idle_d;
        end
    end

    // In RUN the fetch stage owns the memory address port directly.
    assign mem_address      = (r_state_q == S_RUN) ? fetch_address : r_addr_q;
    assign mem_write_enable = r_we_q;
    assign mem_write_data   = r_wdata_q;
    assign run_flag         = r_run_q;
    assign cpu_reset_n      = r_run_q;
    assign load_error       = r_err_q;
    assign busy             = r_busy_q;
    assign words_loaded     = r_words_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_loader
//  Purpose  : Self-checking bench for program_loader. Frames are built at the
//             frame level (word list -> byte stream, expected writes and
//             checksum) and compared against writes captured from the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int         c_MEM_WORDS = 4;
    localparam int         c_TIMEOUT   = 16;
    localparam logic [7:0] c_SYNC      = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_error;
    logic [31:0] fetch_address;
    logic [31:0] mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic        run_flag;
    logic        cpu_reset_n;
    logic        load_error;
    logic        busy;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;

    logic [7:0]  bq[$];
    logic [63:0] exp_wr[$];
    logic [63:0] obs_wr[$];

    program_loader #(
        .MEM_WORDS      (c_MEM_WORDS),
        .SYNC_BYTE      (c_SYNC),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_error         (rx_error),
        .fetch_address    (fetch_address),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .run_flag         (run_flag),
        .cpu_reset_n      (cpu_reset_n),
        .load_error       (load_error),
        .busy             (busy),
        .words_loaded     (words_loaded)
    );

    always #5 clk = ~clk;

    // Capture every memory write mid-cycle; a strobe held for two cycles
    // shows up as a duplicate entry.
    always @(negedge clk) begin
        if (mem_write_enable === 1'b1) obs_wr.push_back({mem_address, mem_write_data});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic play(input int max_gap);
        foreach (bq[i]) begin
            send_byte(bq[i]);
            if (max_gap > 0 && i != bq.size() - 1) idle($urandom_range(max_gap, 0));
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        @(posedge clk); #1;
        reset_n  = 1'b1;
    endtask

    // Frame-level reference: random words -> byte stream + expected writes.
    function automatic void build_frame(input int n, input bit bad);
        logic [31:0] w;
        logic [7:0]  cs;
        bq.delete();
        exp_wr.delete();
        cs = 8'd0;
        bq.push_back(c_SYNC);
        bq.push_back(8'(n));
        bq.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) begin
                bq.push_back(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
            exp_wr.push_back({32'(i * 4), w});
        end
        bq.push_back(bad ? (cs ^ 8'($urandom_range(255, 1))) : cs);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_address, mem_write_enable, mem_write_data} !== 65'd0) begin
            errors++;
            $display("FAIL reset_mem: got addr=%h we=%b data=%h want all 0",
                     mem_address, mem_write_enable, mem_write_data);
        end
        checks++;
        if ({run_flag, cpu_reset_n, load_error, busy, words_loaded} !== 20'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got run=%b crn=%b err=%b busy=%b words=%0d want all 0",
                     run_flag, cpu_reset_n, load_error, busy, words_loaded);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        obs_wr.delete();
        bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        for (int i = 0; i < 7; i++) send_byte(bq[i]);
        checks++;
        if ({mem_write_enable, mem_address, mem_write_data, words_loaded} !== {1'b1, 32'h0, 32'h13, 16'd1}) begin
            errors++;
            $display("FAIL nominal_w0: got we=%b addr=%h data=%h words=%0d want 1 0 00000013 1",
                     mem_write_enable, mem_address, mem_write_data, words_loaded);
        end
        send_byte(bq[7]);
        checks++;
        if (mem_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL nominal_strobe_len: got we=%b want 0", mem_write_enable);
        end
        for (int i = 8; i < 11; i++) send_byte(bq[i]);
        checks++;
        if ({mem_write_enable, mem_address, mem_write_data, words_loaded, busy} !== {1'b1, 32'h4, 32'h00100093, 16'd2, 1'b1}) begin
            errors++;
            $display("FAIL nominal_w1: got we=%b addr=%h data=%h words=%0d busy=%b want 1 4 00100093 2 1",
                     mem_write_enable, mem_address, mem_write_data, words_loaded, busy);
        end
        send_byte(bq[11]);
        checks++;
        if ({run_flag, cpu_reset_n, load_error, busy, words_loaded} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'd2}) begin
            errors++;
            $display("FAIL nominal_run: got run=%b crn=%b err=%b busy=%b words=%0d want 1 1 0 0 2",
                     run_flag, cpu_reset_n, load_error, busy, words_loaded);
        end
        fetch_address = $urandom;
        #1;
        checks++;
        if (mem_address !== fetch_address) begin
            errors++;
            $display("FAIL nominal_fetch_pass: got %h want %h", mem_address, fetch_address);
        end
        // Traffic in RUN must be ignored.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        rx_error = 1'b1; idle(1); rx_error = 1'b0;
        checks++;
        if ({run_flag, load_error, busy, words_loaded} !== {1'b1, 1'b0, 1'b0, 16'd2}) begin
            errors++;
            $display("FAIL run_terminal: got run=%b err=%b busy=%b words=%0d want 1 0 0 2",
                     run_flag, load_error, busy, words_loaded);
        end
        exp_wr = '{{32'h0, 32'h00000013}, {32'h4, 32'h00100093}};
        checks++;
        if (obs_wr != exp_wr) begin
            errors++;
            $display("FAIL nominal_writes: got %0d writes want %0d (content differs)",
                     obs_wr.size(), exp_wr.size());
        end
    endtask

    task automatic test_bad_csum();
        do_reset();
        obs_wr.delete();
        bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
        exp_wr = '{{32'h0, 32'h00000013}, {32'h4, 32'h00100093}};
        play(0);
        checks++;
        if ({load_error, run_flag, cpu_reset_n, busy} !== 4'b1000 || obs_wr != exp_wr) begin
            errors++;
            $display("FAIL bad_csum: got err=%b run=%b crn=%b busy=%b writes=%0d want 1 0 0 0 writes=2",
                     load_error, run_flag, cpu_reset_n, busy, obs_wr.size());
        end
        obs_wr.delete();
        bq[11] = 8'h90;
        play(0);
        checks++;
        if ({load_error, run_flag, cpu_reset_n} !== 3'b011 || obs_wr != exp_wr) begin
            errors++;
            $display("FAIL bad_csum_resend: got err=%b run=%b crn=%b writes=%0d want 0 1 1 writes=2",
                     load_error, run_flag, cpu_reset_n, obs_wr.size());
        end
    endtask

    task automatic test_len_bounds();
        do_reset();
        obs_wr.delete();
        bq = '{8'hA5, 8'h00, 8'h00};
        play(0);
        checks++;
        if ({load_error, busy, words_loaded} !== {1'b1, 1'b0, 16'd0} || obs_wr.size() != 0) begin
            errors++;
            $display("FAIL len_zero: got err=%b busy=%b words=%0d writes=%0d want 1 0 0 0",
                     load_error, busy, words_loaded, obs_wr.size());
        end
        send_byte(8'hA5);
        checks++;
        if ({load_error, busy} !== 2'b01) begin
            errors++;
            $display("FAIL err_resync: got err=%b busy=%b want 0 1", load_error, busy);
        end
        send_byte(8'h05); send_byte(8'h00);
        checks++;
        if ({load_error, busy} !== 2'b10) begin
            errors++;
            $display("FAIL len_over: got err=%b busy=%b want 1 0", load_error, busy);
        end
        obs_wr.delete();
        build_frame(4, 1'b0);
        play(0);
        checks++;
        if ({run_flag, load_error, words_loaded} !== {1'b1, 1'b0, 16'd4} || obs_wr != exp_wr) begin
            errors++;
            $display("FAIL len_max: got run=%b err=%b words=%0d writes=%0d want 1 0 4 writes=4",
                     run_flag, load_error, words_loaded, obs_wr.size());
        end
    endtask

    task automatic test_garbage();
        do_reset();
        obs_wr.delete();
        build_frame(3, 1'b0);
        bq.push_front(8'h5A); bq.push_front(8'hFF); bq.push_front(8'h00);
        play(0);
        checks++;
        if ({run_flag, load_error, words_loaded} !== {1'b1, 1'b0, 16'd3} || obs_wr != exp_wr) begin
            errors++;
            $display("FAIL garbage: got run=%b err=%b words=%0d writes=%0d want 1 0 3 writes=3",
                     run_flag, load_error, words_loaded, obs_wr.size());
        end
    endtask

    task automatic test_timeout();
        // 16 idle cycles after the second byte of a data word abort.
        do_reset();
        build_frame(1, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(bq[i]);
        idle(c_TIMEOUT - 1);
        checks++;
        if ({busy, load_error} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_early: got busy=%b err=%b want 1 0", busy, load_error);
        end
        idle(1);
        checks++;
        if ({busy, load_error, run_flag} !== 3'b010) begin
            errors++;
            $display("FAIL timeout_abort: got busy=%b err=%b run=%b want 0 1 0", busy, load_error, run_flag);
        end
        // 15 idle cycles then a byte continues normally.
        do_reset();
        obs_wr.delete();
        build_frame(2, 1'b0);
        for (int i = 0; i < bq.size(); i++) begin
            send_byte(bq[i]);
            if (i == 4) idle(c_TIMEOUT - 1);
        end
        checks++;
        if ({run_flag, load_error} !== 2'b10 || obs_wr != exp_wr) begin
            errors++;
            $display("FAIL timeout_continue: got run=%b err=%b writes=%0d want 1 0 writes=2",
                     run_flag, load_error, obs_wr.size());
        end
    endtask

    task automatic test_rx_error();
        do_reset();
        // Error strobe together with a SYNC byte in IDLE: byte discarded.
        rx_valid = 1'b1; rx_error = 1'b1; rx_data = c_SYNC;
        idle(1);
        rx_valid = 1'b0; rx_error = 1'b0;
        checks++;
        if ({busy, load_error} !== 2'b00) begin
            errors++;
            $display("FAIL rx_error_discard: got busy=%b err=%b want 0 0", busy, load_error);
        end
        obs_wr.delete();
        build_frame(2, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(bq[i]);
        rx_valid = 1'b1; rx_error = 1'b1; rx_data = bq[5];
        idle(1);
        rx_valid = 1'b0; rx_error = 1'b0;
        checks++;
        if ({busy, load_error, run_flag} !== 3'b010 || obs_wr.size() != 0) begin
            errors++;
            $display("FAIL rx_error_data: got busy=%b err=%b run=%b writes=%0d want 0 1 0 0",
                     busy, load_error, run_flag, obs_wr.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        build_frame(2, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(bq[i]);
        reset_n = 1'b0;
        idle(1);
        checks++;
        if ({mem_address, mem_write_enable, mem_write_data, run_flag, cpu_reset_n,
             load_error, busy, words_loaded} !== 85'd0) begin
            errors++;
            $display("FAIL reset_mid: got addr=%h we=%b data=%h run=%b crn=%b err=%b busy=%b words=%0d want all 0",
                     mem_address, mem_write_enable, mem_write_data, run_flag, cpu_reset_n,
                     load_error, busy, words_loaded);
        end
        reset_n = 1'b1;
        obs_wr.delete();
        build_frame(2, 1'b0);
        play(0);
        checks++;
        if ({run_flag, load_error} !== 2'b10 || obs_wr != exp_wr) begin
            errors++;
            $display("FAIL reset_mid_reload: got run=%b err=%b writes=%0d want 1 0 writes=2",
                     run_flag, load_error, obs_wr.size());
        end
    endtask

    task automatic test_random();
        int  n;
        bit  bad;
        logic [7:0] g;
        for (int it = 0; it < 10; it++) begin
            do_reset();
            obs_wr.delete();
            n   = $urandom_range(c_MEM_WORDS, 1);
            bad = ($urandom_range(2, 0) == 0);
            build_frame(n, bad);
            repeat ($urandom_range(3, 0)) begin
                g = 8'($urandom);
                if (g == c_SYNC) g = 8'h00;
                bq.push_front(g);
            end
            play(3);
            checks++;
            if ({run_flag, cpu_reset_n, load_error, busy, words_loaded} !== {!bad, !bad, bad, 1'b0, 16'(n)}
                || obs_wr != exp_wr) begin
                errors++;
                $display("FAIL random_%0d: got run=%b crn=%b err=%b busy=%b words=%0d writes=%0d want run=%b err=%b words=%0d writes=%0d",
                         it, run_flag, cpu_reset_n, load_error, busy, words_loaded, obs_wr.size(),
                         !bad, bad, n, exp_wr.size());
            end
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        rx_valid      = 1'b0;
        rx_data       = 8'd0;
        rx_error      = 1'b0;
        fetch_address = 32'd0;
        @(posedge clk); #1;
        test_reset();
        test_nominal();
        test_bad_csum();
        test_len_bounds();
        test_garbage();
        test_timeout();
        test_rx_error();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
